// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order imem requests against a credit limit,
// tags responses with their PC and buffers them for decode; steers the PC via pc_opcode.
module fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_address,
   output logic [1:0]  pc_opcode,
   output logic [31:0] pc_target,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   input  logic        id_ready
);

   localparam int P = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int W = P + 1;

   localparam logic [0:0] ST_BOOT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [1:0] OP_INC  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_HOLD = 2'b10;
   localparam logic [1:0] OP_ZERO = 2'b11;

   localparam logic [P-1:0] PTR_ONE    = P'(1);
   localparam logic [W-1:0] CNT_ONE    = W'(1);
   localparam logic [W:0]   CREDIT_MAX = (W+1)'(DEPTH);

   logic [0:0]   state_q, state_d;
   logic [W-1:0] count_q, count_d;
   logic [W-1:0] outstanding_q, outstanding_d;
   logic [W-1:0] discard_q, discard_d;
   logic [P-1:0] rd_ptr_q, rd_ptr_d;
   logic [P-1:0] wr_ptr_q, wr_ptr_d;
   logic [P-1:0] aq_rd_q, aq_rd_d;
   logic [P-1:0] aq_wr_q, aq_wr_d;

   logic [31:0] fifo_instr_mem [DEPTH];
   logic [31:0] fifo_pc_mem    [DEPTH];
   logic [31:0] addr_mem       [DEPTH];

   logic         run;
   logic         pop;
   logic         issue;
   logic         gnt_evt;
   logic         rsp_live;
   logic         kept;
   logic [W:0]   credit_sum;

   assign id_valid  = (count_q != '0);
   assign id_instr  = id_valid ? fifo_instr_mem[rd_ptr_q] : '0;
   assign id_pc     = id_valid ? fifo_pc_mem[rd_ptr_q] : '0;
   assign imem_req  = issue;
   assign imem_addr = pc_address;
   assign pc_target = redirect_target;

   // Credit covers buffered words plus every in-flight response, stale ones included.
   always_comb begin
      run        = (state_q == ST_RUN);
      pop        = id_valid & id_ready;
      credit_sum = {1'b0, outstanding_q} + {1'b0, count_q} - {{W{1'b0}}, pop};
      issue      = run & ~redirect_valid & (credit_sum < CREDIT_MAX);
      gnt_evt    = issue & imem_gnt;
      rsp_live   = imem_rvalid & (outstanding_q != '0);
      kept       = rsp_live & ~redirect_valid & (discard_q == '0);
   end

   always_comb begin
      pc_opcode = OP_HOLD;
      if (!run)                pc_opcode = OP_ZERO;
      else if (redirect_valid) pc_opcode = OP_LOAD;
      else if (gnt_evt)        pc_opcode = OP_INC;
   end

   always_comb begin
      state_d       = ST_RUN;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      aq_rd_d       = aq_rd_q;
      aq_wr_d       = aq_wr_q;

      if (gnt_evt && !rsp_live)      outstanding_d = outstanding_q + CNT_ONE;
      else if (!gnt_evt && rsp_live) outstanding_d = outstanding_q - CNT_ONE;

      if (redirect_valid) begin
         // A response landing in the redirect cycle is already accounted as dropped.
         discard_d = rsp_live ? (outstanding_q - CNT_ONE) : outstanding_q;
         count_d   = '0;
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
         aq_rd_d   = '0;
         aq_wr_d   = '0;
      end else begin
         if (rsp_live && (discard_q != '0)) discard_d = discard_q - CNT_ONE;
         if (kept && !pop)      count_d = count_q + CNT_ONE;
         else if (!kept && pop) count_d = count_q - CNT_ONE;
         if (kept)    wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (gnt_evt) aq_wr_d  = aq_wr_q + PTR_ONE;
         if (kept)    aq_rd_d  = aq_rd_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_BOOT;
         count_q       <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         aq_rd_q       <= '0;
         aq_wr_q       <= '0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         aq_rd_q       <= aq_rd_d;
         aq_wr_q       <= aq_wr_d;
      end
   end

   // Storage needs no reset: occupancy is tracked solely by the pointers and counts.
   always_ff @(posedge clk) begin
      if (kept) begin
         fifo_instr_mem[wr_ptr_q] <= imem_rdata;
         fifo_pc_mem[wr_ptr_q]    <= addr_mem[aq_rd_q];
      end
      if (gnt_evt) addr_mem[aq_wr_q] <= pc_address;
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(imem_rvalid && (outstanding_q == '0)));
         assert (RESET_PC[1:0] == 2'b00);
      end
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly downstream of the program counter.
- Consumes the PC address, issues in-order requests to instruction memory, buffers returned words in a DEPTH-entry FIFO, and presents {instr, pc} to decode with valid/ready.
- Closes the loop by driving the PC's 2-bit OPcode and target address:
  - 00: +4
  - 01: load
  - 10: hold
  - 11: zero

Parameters:
- DEPTH, 4: instruction buffer entries and maximum outstanding requests; power of 2, minimum 2.
- RESET_PC, 0: informational only; reset vector is produced by PC OPcode 11.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- pc_address  in  32  current PC value.
- pc_opcode  out  2  PC command: 00 +4, 01 load pc_target, 10 hold, 11 zero.
- pc_target  out  32  load address for PC; equals redirect_target.
- redirect_valid  in  1  branch/jump redirect; flushes the stage.
- redirect_target  in  32  new fetch address.
- imem_req  out  1  fetch request.
- imem_addr  out  32  request address; equals pc_address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid, in order; earliest one cycle after gnt.
- imem_rdata  in  32  instruction word.
- id_valid  out  1  buffer head valid.
- id_instr  out  32  head instruction.
- id_pc  out  32  head instruction address.
- id_ready  in  1  decode accepts head.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State=BOOT; FIFO empty; outstanding=0; discard=0.
  - imem_req=0, id_valid=0, id_instr=0, id_pc=0.
  - pc_opcode=11, so the PC zeroes on every edge while reset is held.
- States:
  - BOOT: pc_opcode=11, imem_req=0. Lasts exactly one cycle after rst_n rises, then goes to RUN.
  - RUN: normal operation.
- Credit rule: issue = RUN & !redirect_valid & (outstanding + count − pop < DEPTH), where pop = id_valid & id_ready.
  - Sustains one instruction per cycle with id_ready=1 and 1-cycle memory.
- Request behaviour:
  - imem_req = issue; imem_addr = pc_address.
  - Request and address stay stable until gnt; the PC is held via OPcode 10.
  - The one exception: redirect may withdraw an ungranted request.
- pc_opcode priority, combinational:
  - reset or BOOT → 11.
  - redirect_valid → 01.
  - imem_req & imem_gnt → 00.
  - else → 10.
- Tagging:
  - On gnt, pc_address is pushed into an internal DEPTH-entry address queue.
  - On a kept rvalid, the head of the address queue is popped and {imem_rdata, tag} is written into the FIFO.
  - id_valid rises the cycle after rvalid; there is no bypass.
- outstanding counter:
  - +1 on gnt, −1 on rvalid; simultaneous events net to 0.
  - Width clog2(DEPTH)+1.
  - Receiving rvalid while outstanding=0 is a protocol error; flagged by an assertion, counter saturates at 0.
- FIFO:
  - Circular, with wrap-around pointers.
  - Push and pop in the same cycle while full is legal.
  - Push while full cannot occur, by the credit rule.
- Redirect (one cycle, highest priority):
  - FIFO and address queue are cleared.
  - discard ← outstanding − (imem_rvalid ? 1 : 0); an rvalid arriving in the same cycle is dropped.
  - A pop in the same cycle is still considered consumed by decode.
  - id_valid=0 from the next cycle.
- Discard:
  - While discard>0, each rvalid decrements discard and is dropped without a FIFO write.
  - Issue is allowed during discard; credit counts both discard and outstanding.
  - Responses are in order, so new responses follow the stale ones.
- Back-to-back redirects: each one recomputes discard from the current outstanding count.
- id outputs are registered from the FIFO head and stable while id_valid & !id_ready.
- Reset asserted mid-operation: immediate return to reset values; late memory responses after reset are the memory's responsibility (memory shares rst_n).

Test Plan:
- Reset/boot: hold rst_n=0 for 3 cycles, then release → pc_opcode=11 during reset and 1 cycle after; then imem_req=1 with imem_addr=0x0; id_valid=0 throughout.
- Streaming: gnt=1 always, rvalid one cycle after gnt, rdata=addr+0x1000, id_ready=1 → id_pc 0,4,8,C on consecutive cycles with id_instr 0x1000,0x1004,…; pc_opcode=00 each cycle.
- Backpressure, DEPTH=4: id_ready=0 → exactly 4 grants, then imem_req=0 and pc_opcode=10 with the PC stuck at 0x10; set id_ready=1 → heads 0,4,8,C drain in order, fetching resumes at 0x10.
- Redirect with in-flight: 2 requests outstanding, FIFO holds 1, redirect to 0x400 → pc_opcode=01 and pc_target=0x400; the 2 late responses are dropped; next id_pc=0x400.
- Redirect coincident with rvalid and pop: the arriving word is dropped; discard=outstanding−1; no stale id_valid after the redirect.
- Slow memory: gnt delayed 3 cycles → imem_req and imem_addr stable, pc_opcode=10 until gnt; assert rst_n=0 mid-stream → outputs reset asynchronously, within the same cycle.
